tt_um_ioannisin_rr_mux_arbiter: RTL and testbench

Round-robin arbiter that shares the 4:1 single-bit mux output between four requesters. Each requester raises a request line; the arbiter grants exactly one at a time, drives the mux select from the registered grant, and forces a handover after a bounded hold time so no requester starves. It sits as a Tiny Tapeout top-level, with the mux as its datapath.

---
 rtl/tt_um_ioannisin_rr_mux_arbiter.sv | 140 ++++++++++++++
 tb/tb_tt_um_ioannisin_rr_mux_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/tt_um_ioannisin_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_ioannisin_rr_mux_arbiter
// Purpose  : Round-robin arbiter for four requesters. It shares a 4:1
//            single-bit mux output between them. The registered grant drives
//            the mux select. When other requesters are waiting, the owner
//            loses the grant after HOLD_MAX cycles, unless hold_lock is set.
// Ports    : clk, rst_n (async, active-low), ena (ignored)
//            ui_in[3:0]   req[3:0]      ui_in[7:4]  d[3:0] mux data
//            uio_in[0]    hold_lock     uio_in[7:1] unused
//            uo_out[3:0]  grant one-hot uo_out[5:4] sel
//            uo_out[6]    y             uo_out[7]   busy
//            uio_out, uio_oe: constant 0
// Revision : 1.0  initial release
// ============================================================================
module tt_um_ioannisin_rr_mux_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] c_cnt_max = 4'(HOLD_MAX - 1);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_sel, w_sel_nxt;
    logic [1:0] r_last, w_last_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;

    logic [3:0] w_req;
    logic [3:0] w_d;
    logic       w_hold_lock;
    logic       w_found;
    logic [1:0] w_winner;
    logic [1:0] w_scan_idx;
    logic       w_busy;
    logic [3:0] w_grant;
    logic       w_y;

    assign w_req       = ui_in[3:0];
    assign w_d         = ui_in[7:4];
    assign w_hold_lock = uio_in[0];

    // Scan last+1, last+2, last+3, then last itself. Because last always names
    // the current owner while busy, the owner is checked last. On a timeout it
    // keeps the grant only when it is the sole requester. On a release its
    // req is 0, so it cannot win.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = r_last;
        w_scan_idx = r_last;
        for (int i = 1; i <= 4; i++) begin
            w_scan_idx = r_last + 2'(i);
            if (!w_found && w_req[w_scan_idx]) begin
                w_found  = 1'b1;
                w_winner = w_scan_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= 2'b00;
            r_last  <= 2'b11;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_winner;
                    w_last_nxt  = w_winner;
                    w_cnt_nxt   = 4'd0;
                end
            end
            GRANT: begin
                if (!w_req[r_sel]) begin
                    // Release: hand over in the same edge, or drop to idle.
                    // In idle, sel keeps the last owner.
                    w_cnt_nxt = 4'd0;
                    if (w_found) begin
                        w_sel_nxt  = w_winner;
                        w_last_nxt = w_winner;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (!w_hold_lock && (r_cnt == c_cnt_max)) begin
                    // Timeout: the owner still requests, so w_found is set.
                    w_sel_nxt  = w_winner;
                    w_last_nxt = w_winner;
                    w_cnt_nxt  = 4'd0;
                end else if (r_cnt != c_cnt_max) begin
                    // With hold_lock set, cnt saturates at c_cnt_max. A timeout
                    // then fires on the first edge after hold_lock falls.
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_busy  = (r_state == GRANT);
    assign w_grant = w_busy ? (4'b0001 << r_sel) : 4'b0000;
    assign w_y     = w_busy ? w_d[r_sel] : 1'b0;

    assign uo_out  = {w_busy, w_y, r_sel, w_grant};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic w_unused;
    assign w_unused = &{1'b0, ena, uio_in[7:1]};

endmodule
`default_nettype wire

// File: tb/tb_tt_um_ioannisin_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_um_ioannisin_rr_mux_arbiter
// Purpose  : Directed self-checking bench for the round-robin mux arbiter.
//            The expected uo_out values are worked out by hand as
//            {busy, y, sel[1:0], grant[3:0]}.
// Revision : 1.0  initial release
// ============================================================================
module tb_tt_um_ioannisin_rr_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_tests = 0;
    int n_fail  = 0;

    tt_um_ioannisin_rr_mux_arbiter #(.HOLD_MAX(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] s;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #12;
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);
        rst_n = 1'b1;

        // Round robin with all four requesting: each owner holds for 8 cycles.
        ui_in = 8'h0F;
        for (int k = 0; k < 5; k++) begin
            s = 2'(k % 4);
            for (int c = 0; c < 8; c++) begin
                tick(1);
                check("round_robin", uo_out, {1'b1, 1'b0, s, 4'b0001 << s});
            end
        end

        // Asynchronous reset in the middle of a grant.
        rst_n = 1'b0;
        #1;
        check("async_reset", uo_out, 8'h00);
        ui_in = 8'h01;
        #2;
        rst_n = 1'b1;
        tick(1);
        check("post_reset_grant0", uo_out, 8'h81);

        // Release handover: owner 0 to owner 1, then 1 to 2 with req=1100.
        ui_in = 8'h02;
        tick(1);
        check("handover_to1", uo_out, 8'h92);
        ui_in = 8'h0C;
        tick(1);
        check("handover_to2", uo_out, 8'hA4);
        tick(7);
        check("cnt_restart_hold", uo_out, 8'hA4);
        tick(1);
        check("timeout_to3", uo_out, 8'hB8);
        ui_in = 8'h00;
        tick(1);
        check("release_idle", uo_out, 8'h30);

        // Sole requester keeps the grant across timeouts.
        ui_in = 8'h04;
        tick(1);
        check("sole_grant", uo_out, 8'hA4);
        for (int c = 0; c < 20; c++) begin
            tick(1);
            check("sole_timeout", uo_out, 8'hA4);
        end

        // hold_lock suppresses preemption.
        ui_in = 8'h00;
        tick(1);
        check("idle_sel_holds", uo_out, 8'h20);
        ui_in = 8'h01;
        tick(1);
        check("lock_owner0", uo_out, 8'h81);
        ui_in  = 8'h03;
        uio_in = 8'h01;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            check("hold_lock", uo_out, 8'h81);
        end
        uio_in = 8'h00;
        tick(1);
        check("lock_drop", uo_out, 8'h92);

        // Datapath: owner 2 with d[0]=1 static; y follows d[2] only.
        ui_in = 8'h14;
        tick(1);
        check("dp_d2_0", uo_out, 8'hA4);
        ui_in = 8'h54;
        #1;
        check("dp_d2_1", uo_out, 8'hE4);
        ui_in = 8'h14;
        #1;
        check("dp_d2_back0", uo_out, 8'hA4);
        ui_in = 8'h44;
        #1;
        check("dp_d0_cleared", uo_out, 8'hE4);

        // y is forced low in idle even with all data bits set.
        ui_in = 8'hF0;
        tick(1);
        check("dp_idle_y0", uo_out, 8'h20);
        check("uio_out_zero", uio_out, 8'h00);
        check("uio_oe_zero", uio_oe, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
